mem_2: RTL and testbench

Single-port-pair synchronous RAM with one write port and one registered read port, both on `clk`. It serves as the operand storage memory in the dot-product datapath. Upstream logic writes one word per cycle and downstream logic reads one word per cycle with one-cycle latency. Writes and reads are independent and may occur in the same cycle.

---
 rtl/mem_2.sv | 115 +++++++++++
 tb/tb_mem_2.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_2.sv
// -----------------------------------------------------------------------------
// mem_2 - operand storage RAM for the dot-product datapath.
//
// One write port and one registered read port, both on clk. Writes land at
// the rising edge; reads return data one cycle after the strobe. A read and a
// write to the same location in the same cycle are read-first: the read sees
// the old word, and the new word is visible to a read strobed one cycle later.
//
// Parameters
//   DATA_WIDTH : word width in bits
//   MEM_SIZE   : number of storage words
//   ADDR_WIDTH : address width; reachable range is
//                0 .. min(MEM_SIZE, 2**ADDR_WIDTH)-1
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : synchronous active-low reset
//   write_en      : write strobe
//   write_address : write location (writes at or beyond MEM_SIZE are dropped)
//   data_in       : write data
//   read_en       : read strobe (data_out holds when low)
//   read_address  : read location (reads at or beyond MEM_SIZE return 0)
//   data_out      : registered read data
//
// Build option
//   MEM2_RESET_CLEAR_EN : when defined, every reset edge clears all MEM_SIZE
//                         words to zero. When undefined, reset touches only
//                         data_out and the array keeps its contents.
// -----------------------------------------------------------------------------
module mem_2 #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 64,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Index width sized to the array itself, so the array is never indexed
    // with a narrower or wider vector than it needs.
    localparam int IDX_WIDTH = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [DATA_WIDTH-1:0] mem_r [MEM_SIZE];
    logic [DATA_WIDTH-1:0] data_out_r;

    logic                  write_ok_s;
    logic                  read_ok_s;
    logic [IDX_WIDTH-1:0]  write_idx_s;
    logic [IDX_WIDTH-1:0]  read_idx_s;

    // True when an address falls inside the populated part of the array.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [31:0] wide;
        wide = 32'(addr);
        return (wide < 32'(MEM_SIZE));
    endfunction

    // Array index for an address; only meaningful when addr_in_range holds.
    function automatic logic [IDX_WIDTH-1:0] addr_to_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [31:0] wide;
        wide = 32'(addr);
        return wide[IDX_WIDTH-1:0];
    endfunction

    // Qualify strobes with the address range and derive array indices.
    always_comb begin
        write_ok_s  = write_en & addr_in_range(write_address);
        read_ok_s   = addr_in_range(read_address);
        write_idx_s = addr_to_idx(write_address);
        read_idx_s  = addr_to_idx(read_address);
    end

`ifdef MEM2_RESET_CLEAR_EN
    // Storage update: reset wipes every word in one edge, otherwise accept in-range writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (write_ok_s) begin
            mem_r[write_idx_s] <= data_in;
        end
    end
`else
    // Storage update: contents survive reset; writes are blocked only while reset is low.
    always_ff @(posedge clk) begin
        if (rst_n && write_ok_s) begin
            mem_r[write_idx_s] <= data_in;
        end
    end
`endif

    // Read register: the non-blocking read of mem_r sees the pre-write word,
    // which gives read-first behaviour on a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_r <= {DATA_WIDTH{1'b0}};
        end else if (read_en) begin
            if (read_ok_s) begin
                data_out_r <= mem_r[read_idx_s];
            end else begin
                data_out_r <= {DATA_WIDTH{1'b0}};
            end
        end
    end

    assign data_out = data_out_r;

endmodule

// File: tb/tb_mem_2.sv
// -----------------------------------------------------------------------------
// tb_mem_2 - scoreboard bench for mem_2.
// The driver pushes the expected data_out value for each checked cycle into a
// queue; an independent monitor pops and compares #1 after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_2;

    logic       clk;
    logic       rst_n;
    logic       write_en;
    logic [3:0] write_address;
    logic [7:0] data_in;
    logic       read_en;
    logic [3:0] read_address;
    logic [7:0] data_out;

    typedef struct {
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    logic chk_flag;
    int   checks;
    int   errors;
    logic [7:0] after_reset_exp;

    mem_2 #(.DATA_WIDTH(8), .MEM_SIZE(64), .ADDR_WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_en     (write_en),
        .write_address(write_address),
        .data_in      (data_in),
        .read_en      (read_en),
        .read_address (read_address),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs (called just after a falling edge); optionally
    // queue the data_out value expected right after the coming rising edge.
    task automatic step(input logic rn, input logic we, input logic [3:0] wa,
                        input logic [7:0] di, input logic re, input logic [3:0] ra,
                        input logic chk, input logic [7:0] expv, input string nm);
        exp_t e;
        rst_n         = rn;
        write_en      = we;
        write_address = wa;
        data_in       = di;
        read_en       = re;
        read_address  = ra;
        chk_flag      = chk;
        if (chk) begin
            e.val  = expv;
            e.name = nm;
            sb_q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Monitor: compare data_out against the scoreboard after each checked edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (chk_flag) begin
                #1;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: data_out=%02h with no expectation queued", data_out);
                end else begin
                    e = sb_q.pop_front();
                    if (data_out !== e.val) begin
                        errors++;
                        $display("FAIL %s: data_out=%02h expected %02h", e.name, data_out, e.val);
                    end
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
`ifdef MEM2_RESET_CLEAR_EN
        after_reset_exp = 8'h00;
`else
        after_reset_exp = 8'h11;
`endif
        rst_n = 1'b0; write_en = 1'b0; write_address = 4'h0; data_in = 8'h00;
        read_en = 1'b0; read_address = 4'h0; chk_flag = 1'b0;
        @(negedge clk);

        // Reset held for 25 cycles; last reset edge must leave data_out at 0.
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 8'h00, "");
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00, "reset_value");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00, "reset_idle");

        // Basic write then read-back.
        step(1'b1, 1'b1, 4'h0, 8'h11, 1'b0, 4'h0, 1'b0, 8'h00, "");
        step(1'b1, 1'b1, 4'h1, 8'h22, 1'b0, 4'h0, 1'b0, 8'h00, "");
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 1'b1, 8'h11, "read_addr0");
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 1'b1, 8'h22, "read_addr1");

        // Overwrite location 1; location 0 untouched.
        step(1'b1, 1'b1, 4'h1, 8'hA5, 1'b0, 4'h0, 1'b0, 8'h00, "");
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 1'b1, 8'hA5, "overwrite_addr1");
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 1'b1, 8'h11, "addr0_intact");

        // Read-during-write to the same address is read-first.
        step(1'b1, 1'b1, 4'h1, 8'h22, 1'b0, 4'h0, 1'b0, 8'h00, "");
        step(1'b1, 1'b1, 4'h1, 8'h5A, 1'b1, 4'h1, 1'b1, 8'h22, "rdw_old_data");
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 1'b1, 8'h5A, "rdw_new_data");

        // Hold with read_en low, then reset mid-operation with a write pending.
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 1'b1, 8'h11, "hold_read");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 4'h1, 1'b1, 8'h11, "hold");
        step(1'b0, 1'b1, 4'h0, 8'hFF, 1'b1, 4'h1, 1'b1, 8'h00, "reset_mid_op");
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 1'b1, after_reset_exp, "post_reset_addr0");

        // Full sweep: back-to-back writes then back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = 8'(i) ^ 8'h3C;
            step(1'b1, 1'b1, 4'(i), v, 1'b0, 4'h0, 1'b0, 8'h00, "");
        end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = 8'(i) ^ 8'h3C;
            step(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'(i), 1'b1, v, "sweep_read");
        end

        // Independent read and write to different addresses in one cycle.
        step(1'b1, 1'b1, 4'h2, 8'h77, 1'b1, 4'h3, 1'b1, 8'h3F, "diff_addr_read");
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h2, 1'b1, 8'h77, "diff_addr_write");

        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 8'h00, "");
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 8'h00, "");

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
